down_counter_4bit: RTL and testbench
====================================

Name: down_counter_4bit

Overview:
Loadable down counter with a reload register, auto-reload mode, zero detect and an underflow pulse. It is the count-down partner of the team's 4-bit up counter and is used as a programmable interval/timeout timer. The block sits beside the up counter in the sequential counters library and shares its enable/terminal-count semantics, mirrored for decrementing.

Parameters:
WIDTH, 4, counter and load_value width in bits (legal range 2..16).

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk only.
enable  input  1  count enable; a decrement step is taken on each clk edge with enable=1.
load  input  1  load strobe; count and reload_reg take load_value.
load_value  input  WIDTH  value for the load operation.
auto_reload  input  1  1 = reload from reload_reg on underflow; 0 = free-run/terminal behaviour.
count  output  WIDTH  current counter value (registered).
zero  output  1  combinational, count == 0.
underflow  output  1  combinational, (count == 0) & enable & ~load.
expired  output  1  registered sticky flag: set on underflow, cleared by load or reset.

Behaviour:
- Reset is synchronous only: an asynchronous reset_n edge has no effect until the next rising clk. With reset_n=0 at the edge: count=0, reload_reg=0, expired=0. zero=1 after reset; underflow follows its equation (1 if enable=1 and load=0).
- Reset priority over everything. Asserting reset_n=0 mid-count clears the state on that edge, and no load or decrement occurs on that edge.
- Priority per edge with reset_n=1: load > enable-decrement > hold.
- load=1: count <= load_value, reload_reg <= load_value, expired <= 0. This applies regardless of enable. underflow is forced 0 in that cycle.
- load=0, enable=1, count != 0: count <= count - 1, and reload_reg is unchanged.
- load=0, enable=1, count == 0 (underflow cycle): expired <= 1.
  - With auto_reload=1: count <= reload_reg.
  - With auto_reload=0: count <= all-ones (2^WIDTH - 1), i.e. a modulo wrap. For the saturating alternative, see Optional Feature.
- load=0, enable=0: count, reload_reg and expired hold.
- Auto-reload period: with reload_reg = N and enable held high, underflow pulses once every N+1 cycles. The sequence is N, N-1, ..., 0, N.
- Auto-reload with reload_reg = 0: count stays 0 and underflow is high every enabled cycle.
- load_value = 0 with enable=1 on the next cycle: underflow is asserted immediately in that next cycle.
- Latency: count reflects a load or decrement one clk after the triggering edge. zero and underflow are combinational from count/enable/load with zero added latency.
- auto_reload is sampled only in the underflow cycle, and may change freely otherwise.
- No X propagation: all registers are defined after the first reset edge.

Optional Feature:
Macro DOWN_COUNTER_SAT_EN.
- Defined: with auto_reload=0, an underflow cycle holds count at 0 instead of wrapping. underflow still pulses every enabled cycle while count == 0. expired is set.
- Not defined: modulo wrap to all-ones as described above.
- Auto-reload behaviour, the load path and all ports are identical in both builds.

Test Plan:
1. Reset: reset_n=0 for 2 edges with enable=1 and load=1, then release -> count=0, expired=0, zero=1. Check that reset_n toggled between edges has no effect until a clk edge.
2. Load and count: load_value=5, load pulse, then enable=1 for 5 cycles -> count 5,4,3,2,1,0. In the 6th enabled cycle, underflow=1 and zero=1; on that edge expired becomes 1.
3. Auto-reload period: load 3, auto_reload=1, enable=1 for 12 cycles -> count 3,2,1,0,3,2,1,0,3,2,1,0, with underflow high exactly at each count=0 (every 4 cycles).
4. Wrap vs saturate: load 1, auto_reload=0, enable=1 for 3 cycles.
   - Macro undefined -> 1,0,15, expired=1.
   - DOWN_COUNTER_SAT_EN defined -> 1,0,0, with underflow high in both count=0 cycles.
5. Priority/simultaneous events:
   - At count=0 with enable=1, apply load=1 and load_value=9 -> underflow=0 that cycle, count=9 next, expired cleared.
   - With enable=0 -> count holds over 10 cycles and underflow stays 0.
6. Reset mid-operation: load 12, enable for 4 cycles (count=8), then reset_n=0 for one edge -> count=0, reload_reg=0. A subsequent auto_reload underflow reloads 0, not 12.

Source files
------------

// File: rtl/down_counter_4bit.sv
// Loadable down counter with reload register, auto-reload, zero detect and underflow pulse.
// Build option: define DOWN_COUNTER_SAT_EN to saturate at 0 instead of wrapping when auto_reload=0.
module down_counter_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             underflow,
    output logic             expired
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
        $error("down_counter_4bit: WIDTH must be in 2..16");
    end

    logic [WIDTH-1:0] reload_reg;

    // Value taken on an underflow edge when auto_reload is off.
    function automatic logic [WIDTH-1:0] terminal_value();
`ifdef DOWN_COUNTER_SAT_EN
        return '0;
`else
        return '1;
`endif
    endfunction

    assign zero      = (count == '0);
    assign underflow = zero & enable & ~load;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count      <= '0;
            reload_reg <= '0;
            expired    <= 1'b0;
        end else if (load) begin
            count      <= load_value;
            reload_reg <= load_value;
            expired    <= 1'b0;
        end else if (enable) begin
            if (zero) begin
                count   <= auto_reload ? reload_reg : terminal_value();
                expired <= 1'b1;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_down_counter_4bit.sv
// Directed, table-driven bench for down_counter_4bit (default WIDTH=4); expectations follow the
// DOWN_COUNTER_SAT_EN setting of the build.
module tb_down_counter_4bit;

    logic       clk = 1'b0;
    logic       reset_n, enable, load, auto_reload;
    logic [3:0] load_value;
    logic [3:0] count;
    logic       zero, underflow, expired;

    int n_cmp  = 0;
    int n_fail = 0;

    down_counter_4bit #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .auto_reload(auto_reload),
        .count      (count),
        .zero       (zero),
        .underflow  (underflow),
        .expired    (expired)
    );

    always #5 clk = ~clk;

`ifdef DOWN_COUNTER_SAT_EN
    localparam logic [3:0] T  = 4'd0;
    localparam logic       TZ = 1'b1;
    localparam logic [3:0] T2 = 4'd0;
`else
    localparam logic [3:0] T  = 4'd15;
    localparam logic       TZ = 1'b0;
    localparam logic [3:0] T2 = 4'd14;
`endif

    // Inputs for one edge plus the outputs expected just before that edge.
    typedef struct {
        logic       rn, en, ld, ar, chk;
        logic [3:0] lv;
        logic [3:0] c;
        logic       z, uf, ex;
        string      nm;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string nm, logic rn, logic en, logic ld, logic [3:0] lv, logic ar,
                                logic chk, logic [3:0] c, logic z, logic uf, logic ex);
        vec_t v;
        v.nm = nm; v.rn = rn; v.en = en; v.ld = ld; v.lv = lv; v.ar = ar;
        v.chk = chk; v.c = c; v.z = z; v.uf = uf; v.ex = ex;
        vecs.push_back(v);
    endfunction

    task automatic check(string nm, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(string nm, logic [3:0] c, logic z, logic uf, logic ex);
        check({nm, ".count"}, int'(count), int'(c));
        check({nm, ".zero"}, int'(zero), int'(z));
        check({nm, ".underflow"}, int'(underflow), int'(uf));
        check({nm, ".expired"}, int'(expired), int'(ex));
    endtask

    initial begin
        //   name      rn en ld lv  ar chk cnt z  uf ex
        add("rst0",    0, 1, 1, 7,  0, 0,  0,  0, 0, 0);
        add("rst1",    0, 1, 1, 7,  0, 1,  0,  1, 0, 0);
        add("rst_rel", 1, 0, 0, 0,  0, 1,  0,  1, 0, 0);
        add("ld5",     1, 0, 1, 5,  0, 1,  0,  1, 0, 0);
        add("dn5",     1, 1, 0, 0,  0, 1,  5,  0, 0, 0);
        add("dn4",     1, 1, 0, 0,  0, 1,  4,  0, 0, 0);
        add("dn3",     1, 1, 0, 0,  0, 1,  3,  0, 0, 0);
        add("dn2",     1, 1, 0, 0,  0, 1,  2,  0, 0, 0);
        add("dn1",     1, 1, 0, 0,  0, 1,  1,  0, 0, 0);
        add("uf0",     1, 1, 0, 0,  0, 1,  0,  1, 1, 0);
        add("after_uf",1, 0, 0, 0,  0, 1,  T,  TZ,0, 1);
        add("ld3_ar",  1, 1, 1, 3,  1, 1,  T,  TZ,0, 1);
        for (int p = 0; p < 3; p++) begin
            add("ar3", 1, 1, 0, 0, 1, 1, 3, 0, 0, logic'(p != 0));
            add("ar2", 1, 1, 0, 0, 1, 1, 2, 0, 0, logic'(p != 0));
            add("ar1", 1, 1, 0, 0, 1, 1, 1, 0, 0, logic'(p != 0));
            add("ar0", 1, 1, 0, 0, 1, 1, 0, 1, 1, logic'(p != 0));
        end
        add("pr3",     1, 1, 0, 0,  1, 1,  3,  0, 0, 1);
        add("pr2",     1, 1, 0, 0,  1, 1,  2,  0, 0, 1);
        add("pr1",     1, 1, 0, 0,  1, 1,  1,  0, 0, 1);
        add("pr_ld9",  1, 1, 1, 9,  1, 1,  0,  1, 0, 1);
        add("pr_9",    1, 0, 0, 0,  1, 1,  9,  0, 0, 0);
        add("wr_ld1",  1, 0, 1, 1,  0, 1,  9,  0, 0, 0);
        add("wr1",     1, 1, 0, 0,  0, 1,  1,  0, 0, 0);
        add("wr0",     1, 1, 0, 0,  0, 1,  0,  1, 1, 0);
        add("wrT",     1, 1, 0, 0,  0, 1,  T,  TZ,TZ,1);
        add("wrT2",    1, 0, 0, 0,  0, 1,  T2, TZ,0, 1);
        add("mr_ld12", 1, 0, 1, 12, 1, 1,  T2, TZ,0, 1);
        add("mr12",    1, 1, 0, 0,  1, 1,  12, 0, 0, 0);
        add("mr11",    1, 1, 0, 0,  1, 1,  11, 0, 0, 0);
        add("mr10",    1, 1, 0, 0,  1, 1,  10, 0, 0, 0);
        add("mr9",     1, 1, 0, 0,  1, 1,  9,  0, 0, 0);
        add("mr_rst",  0, 1, 0, 0,  1, 1,  8,  0, 0, 0);
        add("mr_ar0",  1, 1, 0, 0,  1, 1,  0,  1, 1, 0);
        add("mr_ar0b", 1, 1, 0, 0,  1, 1,  0,  1, 1, 1);
        add("lz_ld0",  1, 0, 1, 0,  0, 1,  0,  1, 0, 1);
        add("lz_uf",   1, 1, 0, 0,  0, 1,  0,  1, 1, 0);
        add("lz_after",1, 0, 0, 0,  0, 1,  T,  TZ,0, 1);

        reset_n = 1'b0; enable = 1'b0; load = 1'b0; load_value = '0; auto_reload = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            reset_n = vecs[i].rn; enable = vecs[i].en; load = vecs[i].ld;
            load_value = vecs[i].lv; auto_reload = vecs[i].ar;
            #1;
            if (vecs[i].chk)
                check_all($sformatf("v%0d_%s", i, vecs[i].nm), vecs[i].c, vecs[i].z, vecs[i].uf, vecs[i].ex);
        end

        // Load 6, then pulse reset_n low between edges: nothing may change until an edge samples it.
        @(negedge clk);
        reset_n = 1'b1; enable = 1'b0; load = 1'b1; load_value = 4'd6; auto_reload = 1'b0;
        @(negedge clk);
        load = 1'b0;
        reset_n = 1'b0;
        #2;
        check_all("async_glitch_low", 4'd6, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_all("async_glitch_after", 4'd6, 1'b0, 1'b0, 1'b0);

        // Hold with enable low for 10 edges.
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check_all($sformatf("hold%0d", k), 4'd6, 1'b0, 1'b0, 1'b0);
        end

        // Reset asserted after the edge only takes effect at the next edge.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_pending.count", int'(count), 6);
        @(posedge clk); #1;
        check_all("rst_applied", 4'd0, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
